uart_tx_cfg: RTL
================

# uart_tx_cfg

Runtime-configurable AXI4-Stream UART transmitter: the next-generation transmitter for the UART core, selectable per frame for 5..DATA_WIDTH data bits, parity (none/even/odd/mark), 1 or 2 stop bits, and line-break generation. It sits between a byte/word AXI-stream source (FIFO or host register) and the txd pin. Bit rate is set by a 16× oversampling-compatible prescale (8 clocks per prescale unit).

## Interface
- DATA_WIDTH, 9, maximum data bits per frame (5..9)
- PRESCALE_WIDTH, 16, width of prescale input
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  character, LSB sent first
- s_axis_tvalid  in  1  character valid
- s_axis_tready  out  1  block can accept a character
- txd  out  1  serial output, idle high
- busy  out  1  frame or break in progress
- prescale  in  PRESCALE_WIDTH  bit time = 8*max(prescale,1) clocks
- data_bits  in  4  data bits per frame; <5 → 5, >DATA_WIDTH → DATA_WIDTH
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (always 1)
- stop_bits  in  1  0: one stop bit, 1: two stop bits
- break_req  in  1  level request to hold line in break

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK, BRK_MARK.
- Reset values: s_axis_tready 0, txd 1, busy 0, state IDLE; all registers cleared asynchronously, including mid-frame (txd returns to 1 immediately).
- IDLE: s_axis_tready 1 unless break_req high. Accept on edge with tvalid && tready.
- On accept: latch tdata, clamped data_bits, parity_mode, stop_bits, B = 8*max(prescale,1); txd←0, busy←1, tready←0, state START. Config/prescale changes mid-frame have no effect.
- Bit timer width PRESCALE_WIDTH+3; loaded with B-1, each state lasts exactly B clocks.
- START → DATA: shift out latched bits LSB first, data_bits bits; bits above data_bits ignored.
- DATA → PARITY if parity_mode≠00, else STOP. Parity over transmitted bits only: even → XOR, odd → ~XOR, mark → 1.
- STOP: txd 1 for 1 or 2 bit times, then IDLE: tready←1, busy←0.
- break_req sampled only in IDLE; has priority over tvalid when both high same edge. IDLE→BREAK: txd←0, busy←1, tready 0. Hold while break_req high (minimum one clock). On break_req low: txd←1, BRK_MARK for B clocks (B from prescale latched at break entry), then IDLE.
- break_req asserted mid-frame: ignored until IDLE; current frame completes.

## Timing
- Frame length N = 1 + data_bits + (parity?1:0) + (stop_bits?2:1) bit times.
- Accept on edge k: txd falls at edge k; each bit boundary at edge k+i*B; IDLE, tready=1, busy=0 at edge k+N*B.
- Back-to-back: with tvalid held, next accept at edge k+N*B+1 (exactly one idle-high clock between frames).
- s_axis_tready is registered; it first rises on the first clk edge after rst deassertion.
- busy high from accept edge to edge k+N*B inclusive-exclusive; never high in IDLE.

## Test plan
- prescale=1, data_bits=8, parity 00, stop 0, tdata 0x55 → txd 0,1,0,1,0,1,0,1,0,1 each 8 clocks; tready high again 80 clocks after accept.
- prescale=2, data_bits=7, parity 01, stop 1, tdata 0x41 → start, 1000001 (LSB first), parity 0, two stops; 11 bits × 16 clocks = 176; repeat with parity 10 → parity bit 1.
- prescale=0, data_bits=3, tdata 0x1FF (DATA_WIDTH 9) → treated as prescale 1 and 5 data bits 11111; 7 bits × 8 clocks; bit 5..8 never driven.
- Three characters tvalid held, 8N1 prescale=1 → frames at accept edges 0, 81, 162; txd high exactly one clock between frames; busy low only those clocks.
- break_req high for 100 clocks in IDLE, prescale=1 → txd low 100 clocks, then high 8 clocks with busy 1, tready 0; break_req and tvalid together → break wins, data accepted after BRK_MARK.
- rst pulsed mid-DATA → txd 1, busy 0, tready 0 immediately; next frame after release transmits correctly from START.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream character channel into the configurable UART transmitter.
// Ports: tdata (character, LSB first), tvalid, tready; master = source, slave = uart.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_WIDTH data bits, parity, 1/2 stops, break.
// Ports: clk, rst (async high), s_axis (slave stream), txd, busy, prescale, data_bits,
//        parity_mode, stop_bits, break_req.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 9,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_cfg_if.slave              s_axis,
    output logic                      txd,
    output logic                      busy,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [3:0]                data_bits,
    input  logic [1:0]                parity_mode,
    input  logic                      stop_bits,
    input  logic                      break_req
);
    localparam int TW = PRESCALE_WIDTH + 3;
    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK, BRK_MARK
    } state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [TW-1:0]         bval, bval_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [3:0]            nbits, nbits_n;
    logic [3:0]            cnt, cnt_n;
    logic                  has_par, has_par_n;
    logic                  stop2, stop2_n;
    logic                  stop_cnt, stop_cnt_n;
    logic                  par, par_n;
    logic                  txd_q, txd_n;
    logic                  busy_q, busy_n;
    logic                  rdy_q, rdy_n;

    logic [3:0]                bits_clamp;
    logic [PRESCALE_WIDTH-1:0] pre_eff;
    logic [TW-1:0]             b_new;
    logic                      x_new;
    logic                      par_new;
    logic                      accept;
    logic                      done;

    // Break request wins over a pending character, so hide tready while it is up.
    assign s_axis.tready = rdy_q & ~break_req;
    assign accept        = rdy_q & s_axis.tvalid & ~break_req;
    assign done          = (timer == '0);
    assign txd           = txd_q;
    assign busy          = busy_q;

    always_comb begin
        bits_clamp = data_bits;
        if (data_bits < 4'd5)
            bits_clamp = 4'd5;
        else if (data_bits > DW4)
            bits_clamp = DW4;
    end

    assign pre_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    assign b_new   = {pre_eff, 3'b000};

    // Parity covers only the bits that will actually be sent.
    always_comb begin
        x_new = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (4'(i) < bits_clamp)
                x_new = x_new ^ s_axis.tdata[i];
        case (parity_mode)
            2'b10:   par_new = ~x_new;
            2'b11:   par_new = 1'b1;
            default: par_new = x_new;
        endcase
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        bval_n     = bval;
        shreg_n    = shreg;
        nbits_n    = nbits;
        cnt_n      = cnt;
        has_par_n  = has_par;
        stop2_n    = stop2;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        txd_n      = txd_q;
        busy_n     = busy_q;
        rdy_n      = rdy_q;
        if (state != IDLE && state != BREAK && !done)
            timer_n = timer - TW'(1);
        case (state)
            IDLE: begin
                rdy_n  = 1'b1;
                busy_n = 1'b0;
                txd_n  = 1'b1;
                if (break_req) begin
                    state_n = BREAK;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                    rdy_n   = 1'b0;
                    bval_n  = b_new;
                end else if (accept) begin
                    state_n   = START;
                    txd_n     = 1'b0;
                    busy_n    = 1'b1;
                    rdy_n     = 1'b0;
                    shreg_n   = s_axis.tdata;
                    nbits_n   = bits_clamp;
                    has_par_n = (parity_mode != 2'b00);
                    stop2_n   = stop_bits;
                    par_n     = par_new;
                    bval_n    = b_new;
                    timer_n   = b_new - TW'(1);
                end
            end
            START: if (done) begin
                state_n = DATA;
                timer_n = bval - TW'(1);
                txd_n   = shreg[0];
                shreg_n = shreg >> 1;
                cnt_n   = 4'd1;
            end
            DATA: if (done) begin
                timer_n = bval - TW'(1);
                if (cnt == nbits) begin
                    if (has_par) begin
                        state_n = PARITY;
                        txd_n   = par;
                    end else begin
                        state_n    = STOP;
                        txd_n      = 1'b1;
                        stop_cnt_n = stop2;
                    end
                end else begin
                    txd_n   = shreg[0];
                    shreg_n = shreg >> 1;
                    cnt_n   = cnt + 4'd1;
                end
            end
            PARITY: if (done) begin
                state_n    = STOP;
                timer_n    = bval - TW'(1);
                txd_n      = 1'b1;
                stop_cnt_n = stop2;
            end
            STOP: if (done) begin
                timer_n = bval - TW'(1);
                if (stop_cnt) begin
                    stop_cnt_n = 1'b0;
                end else begin
                    state_n = IDLE;
                    rdy_n   = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            BREAK: if (!break_req) begin
                state_n = BRK_MARK;
                txd_n   = 1'b1;
                timer_n = bval - TW'(1);
            end
            BRK_MARK: if (done) begin
                state_n = IDLE;
                rdy_n   = 1'b1;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
                rdy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bval     <= '0;
            shreg    <= '0;
            nbits    <= '0;
            cnt      <= '0;
            has_par  <= 1'b0;
            stop2    <= 1'b0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bval     <= bval_n;
            shreg    <= shreg_n;
            nbits    <= nbits_n;
            cnt      <= cnt_n;
            has_par  <= has_par_n;
            stop2    <= stop2_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            txd_q    <= txd_n;
            busy_q   <= busy_n;
            rdy_q    <= rdy_n;
        end
    end
endmodule
